mr1_mem_arbiter: RTL and testbench
==================================

# mr1_mem_arbiter

Shares one memory port between the MR1 instruction-fetch and data request/response buses. It arbitrates requests and tracks outstanding reads in an in-order ID FIFO. It routes each memory response back to the requester that issued it. It sits between the MR1 core and the single-ported memory or bus model used in simulation and formal benches.

## Interface

Parameters:
- MAX_OUTSTANDING, 4: maximum reads in flight (1..16); ID FIFO depth.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- instr_req_valid  in  1  fetch request valid.
- instr_req_ready  out  1  fetch request accepted this cycle.
- instr_req_addr  in  32  fetch address.
- instr_rsp_valid  out  1  fetch response valid.
- instr_rsp_data  out  32  fetch response data.
- data_req_valid  in  1  load/store request valid.
- data_req_ready  out  1  load/store accepted this cycle.
- data_req_wr  in  1  1 = store, 0 = load.
- data_req_size  in  2  0 = byte, 1 = half, 2 = word.
- data_req_addr  in  32  data address.
- data_req_data  in  32  store data.
- data_rsp_valid  out  1  load response valid.
- data_rsp_data  out  32  load response data.
- mem_req_valid  out  1  shared port request valid.
- mem_req_ready  in  1  shared port accepts request.
- mem_req_wr  out  1  shared port write flag.
- mem_req_size  out  2  shared port access size.
- mem_req_addr  out  32  shared port address.
- mem_req_data  out  32  shared port write data.
- mem_rsp_valid  in  1  read response from memory, in request order.
- mem_rsp_data  in  32  read response data.
- rsp_err  out  1  sticky: response arrived with no read outstanding.

## Operation

Grant:
- Each cycle, grant is IDLE, INSTR or DATA.
- Request path is combinational. mem_req_* mirror the granted requester.
- For INSTR, mem_req_wr=0, mem_req_size=2, mem_req_data=0.

Arbitration:
- Fixed priority: DATA wins over INSTR when both are valid.
- A grant is locked while mem_req_valid=1 and mem_req_ready=0. The granted requester and its fields stay on the port until accepted, even if the other side raises valid.

Acceptance:
- Handshake happens when mem_req_valid & mem_req_ready & !full.
- <granted>_req_ready = mem_req_ready & !full & granted. The ungranted ready is 0.
- When full=1, mem_req_valid=0. The lock state is retained.

ID FIFO:
- Every accepted read pushes its requester ID: instr fetch, or data with wr=0.
- Stores push nothing and produce no response.
- count is $clog2(MAX_OUTSTANDING+1) bits wide.
- full = (count == MAX_OUTSTANDING).
- Read and write pointers wrap modulo MAX_OUTSTANDING.

Response routing:
- mem_rsp_valid pops the FIFO head.
- The matching *_rsp_valid pulses in the same cycle, with data passed through combinationally.
- The other *_rsp_valid stays 0.

Simultaneous push and pop: count is unchanged and both take effect.

Boundary cases:
- Pop with full=1 frees a slot on the next cycle, not the same cycle.
- mem_rsp_valid with count=0 drops the response, drives both *_rsp_valid=0, and sets rsp_err. rsp_err clears only on reset.

Reset (reset_n=0 at a clock edge):
- count, pointers, lock, rsp_err and the RR pointer go to 0.
- Grant is IDLE.
- All valid/ready outputs are 0 while reset_n=0.
- A reset mid-transaction discards outstanding IDs. Later responses raise rsp_err.

## Timing

- Request path: 0 cycles from requester valid to mem_req_valid.
- Response path: 0 cycles from mem_rsp_valid to *_rsp_valid.
- Back-to-back accepts are possible every cycle while !full and mem_req_ready=1.
- State (FIFO, lock, rsp_err) updates on the clock edge following the event.
- All outputs are 0 in the cycle reset_n is sampled low, and in the first cycle after release until inputs assert.

## Configuration

MEM_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last-winner register is updated on each accepted request. When both requesters are valid and no lock is held, the one that did not win last time is granted. Reset value favours DATA.
- Undefined: fixed DATA-over-INSTR priority, and the last-winner register is absent.
- Lock, FIFO and response behaviour are identical in both builds.

## Test plan

- Fetch only: instr_req_valid=1, addr=0x100, mem_req_ready=1 -> mem_req_addr=0x100, wr=0, size=2, instr_req_ready=1. Then mem_rsp_valid with data=0x00000013 -> instr_rsp_valid=1, data 0x00000013.
- Contention: both valid, data load addr=0x2000 -> DATA granted first (fixed build). Under MEM_ARB_RR_EN the grants alternate D,I,D,I over 4 accepts. Responses route in order.
- Lock: INSTR granted with mem_req_ready=0 for 3 cycles while data_req_valid rises -> mem_req_addr stays the fetch address and data_req_ready=0 until the fetch is accepted.
- Full: MAX_OUTSTANDING=4, four reads accepted, no responses -> mem_req_valid=0 and both readies 0. One response -> an accept is possible next cycle.
- Store: data_req_wr=1, size=0, data=0xAB -> accepted, count unchanged, no *_rsp_valid. A subsequent response with count=0 -> rsp_err=1 and stays 1.
- Reset mid-flight: 2 reads outstanding, reset_n=0 for 1 cycle -> count=0, all outputs 0. A late mem_rsp_valid -> rsp_err=1.

Source files
------------

// File: rtl/mr1_mem_arbiter.sv
// Shares one memory port between MR1 fetch and data buses; in-order ID FIFO routes read responses.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of fixed DATA-over-INSTR priority.
module mr1_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req_valid,
  output logic        instr_req_ready,
  input  logic [31:0] instr_req_addr,
  output logic        instr_rsp_valid,
  output logic [31:0] instr_rsp_data,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic        data_req_wr,
  input  logic [1:0]  data_req_size,
  input  logic [31:0] data_req_addr,
  input  logic [31:0] data_req_data,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wr,
  output logic [1:0]  mem_req_size,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rsp_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MaxCount = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LastPtr = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {GrIdle, GrInstr, GrData} grant_e;

  grant_e grant, lock_grant_q, lock_grant_d;
  logic lock_q, lock_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] id_q;  // 1 = data requester, 0 = fetch
  logic rsp_err_q;
  logic full, empty, req_pending, hs, push, pop, head_is_data;

`ifdef MEM_ARB_RR_EN
  logic last_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_data_q <= 1'b0;
    end else if (hs) begin
      last_data_q <= (grant == GrData);
    end
  end
`endif

  assign full  = (count_q == MaxCount);
  assign empty = (count_q == '0);

  always_comb begin
    grant = GrIdle;
    if (!reset_n) begin
      grant = GrIdle;
    end else if (lock_q) begin
      grant = lock_grant_q;
    end else if (data_req_valid && instr_req_valid) begin
`ifdef MEM_ARB_RR_EN
      grant = last_data_q ? GrInstr : GrData;
`else
      grant = GrData;
`endif
    end else if (data_req_valid) begin
      grant = GrData;
    end else if (instr_req_valid) begin
      grant = GrInstr;
    end
  end

  always_comb begin
    req_pending  = 1'b0;
    mem_req_wr   = 1'b0;
    mem_req_size = 2'd0;
    mem_req_addr = '0;
    mem_req_data = '0;
    unique case (grant)
      GrInstr: begin
        req_pending  = instr_req_valid;
        mem_req_size = 2'd2;
        mem_req_addr = instr_req_addr;
      end
      GrData: begin
        req_pending  = data_req_valid;
        mem_req_wr   = data_req_wr;
        mem_req_size = data_req_size;
        mem_req_addr = data_req_addr;
        mem_req_data = data_req_data;
      end
      default: ;
    endcase
  end

  assign mem_req_valid   = req_pending && !full;
  assign instr_req_ready = mem_req_ready && !full && (grant == GrInstr);
  assign data_req_ready  = mem_req_ready && !full && (grant == GrData);
  assign hs   = mem_req_valid && mem_req_ready;
  assign push = hs && ((grant == GrInstr) || !data_req_wr);
  assign pop  = reset_n && mem_rsp_valid && !empty;

  assign head_is_data    = id_q[rd_ptr_q];
  assign instr_rsp_valid = pop && !head_is_data;
  assign data_rsp_valid  = pop && head_is_data;
  assign instr_rsp_data  = instr_rsp_valid ? mem_rsp_data : '0;
  assign data_rsp_data   = data_rsp_valid ? mem_rsp_data : '0;
  assign rsp_err         = rsp_err_q && reset_n;

  // A full FIFO blocks the port without releasing or taking a lock.
  always_comb begin
    lock_d       = lock_q;
    lock_grant_d = lock_grant_q;
    if (!full) begin
      lock_d       = req_pending && !mem_req_ready;
      lock_grant_d = lock_d ? grant : GrIdle;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_q       <= 1'b0;
      lock_grant_q <= GrIdle;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      id_q         <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_grant_q <= lock_grant_d;
      count_q      <= count_d;
      if (push) begin
        id_q[wr_ptr_q] <= (grant == GrData);
        wr_ptr_q       <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
      end
      if (mem_rsp_valid && empty) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// Directed bench for mr1_mem_arbiter: scoreboard of expected read responses, immediate assertions.
// Contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mr1_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req_valid, instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        data_req_valid, data_req_ready, data_req_wr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_addr, data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wr;
  logic [1:0]  mem_req_size;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_err;

  typedef struct packed {
    logic        is_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_q[$];
  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mr1_mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr_req_valid (instr_req_valid),
    .instr_req_ready (instr_req_ready),
    .instr_req_addr  (instr_req_addr),
    .instr_rsp_valid (instr_rsp_valid),
    .instr_rsp_data  (instr_rsp_data),
    .data_req_valid  (data_req_valid),
    .data_req_ready  (data_req_ready),
    .data_req_wr     (data_req_wr),
    .data_req_size   (data_req_size),
    .data_req_addr   (data_req_addr),
    .data_req_data   (data_req_data),
    .data_rsp_valid  (data_rsp_valid),
    .data_rsp_data   (data_rsp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_wr      (mem_req_wr),
    .mem_req_size    (mem_req_size),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .rsp_err         (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_data, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.data    = rdata;
    sb_q.push_back(e);
    mem_q.push_back(rdata);
  endtask

  // One request offered with mem_req_ready=1; expected to be accepted in this cycle.
  task automatic do_req(input string tag, input logic is_data, input logic wr,
                        input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input bit track);
    if (is_data) begin
      data_req_valid = 1'b1;
      data_req_wr    = wr;
      data_req_size  = size;
      data_req_addr  = addr;
      data_req_data  = wdata;
    end else begin
      instr_req_valid = 1'b1;
      instr_req_addr  = addr;
    end
    mem_req_ready = 1'b1;
    #1;
    check({tag, "_mvld"}, mem_req_valid, 1'b1);
    check({tag, "_iready"}, instr_req_ready, !is_data);
    check({tag, "_dready"}, data_req_ready, is_data);
    check({tag, "_addr"}, mem_req_addr, addr);
    check({tag, "_wr"}, mem_req_wr, is_data ? wr : 1'b0);
    check({tag, "_size"}, mem_req_size, is_data ? size : 2'd2);
    check({tag, "_wdata"}, mem_req_data, is_data ? wdata : 32'h0);
    if (track && (!is_data || !wr)) push_exp(is_data, rdata);
    tick();
    instr_req_valid = 1'b0;
    data_req_valid  = 1'b0;
    data_req_wr     = 1'b0;
  endtask

  // Drives one memory response and checks its routing without advancing the clock.
  task automatic rsp_begin(input string tag);
    exp_t e;
    if (sb_q.size() == 0 || mem_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: no outstanding read expected, got response slot", tag);
      return;
    end
    e = sb_q.pop_front();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = mem_q.pop_front();
    #1;
    check({tag, "_ivld"}, instr_rsp_valid, !e.is_data);
    check({tag, "_dvld"}, data_rsp_valid, e.is_data);
    check({tag, "_data"}, e.is_data ? data_rsp_data : instr_rsp_data, e.data);
  endtask

  task automatic do_rsp(input string tag);
    rsp_begin(tag);
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  initial begin
    logic exp_d;
    reset_n = 1'b0;
    instr_req_valid = 1'b1; instr_req_addr = 32'h0;
    data_req_valid = 1'b0; data_req_wr = 1'b0; data_req_size = 2'd0;
    data_req_addr = '0; data_req_data = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // Reset: outputs held low even with a request offered.
    tick();
    check("rst_mvld", mem_req_valid, 1'b0);
    check("rst_iready", instr_req_ready, 1'b0);
    check("rst_err", rsp_err, 1'b0);
    tick();
    reset_n = 1'b1; instr_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    check("idle_mvld", mem_req_valid, 1'b0);
    check("idle_dready", data_req_ready, 1'b0);
    check("idle_rspv", {instr_rsp_valid, data_rsp_valid}, 2'b00);
    tick();

    // Fetch only.
    do_req("fetch", 1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0000_0013, 1'b1);
    do_rsp("fetch_rsp");

    // Contention: four accepts with both requesters valid.
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      instr_req_valid = 1'b1; instr_req_addr = 32'h104;
      data_req_valid = 1'b1; data_req_wr = 1'b0; data_req_size = 2'd2;
      data_req_addr = 32'h2000 + 32'(4 * k);
      mem_req_ready = 1'b1;
      #1;
      check($sformatf("cont%0d_dready", k), data_req_ready, exp_d);
      check($sformatf("cont%0d_iready", k), instr_req_ready, !exp_d);
      check($sformatf("cont%0d_addr", k), mem_req_addr,
            exp_d ? 32'h2000 + 32'(4 * k) : 32'h104);
      push_exp(exp_d, 32'hD000_0000 + 32'(k));
      tick();
    end
    data_req_valid = 1'b0;

    // Full: four reads outstanding block the port.
    instr_req_addr = 32'h300;
    #1;
    check("full_mvld", mem_req_valid, 1'b0);
    check("full_iready", instr_req_ready, 1'b0);
    check("full_dready", data_req_ready, 1'b0);
    rsp_begin("full_rsp");
    check("full_pop_iready", instr_req_ready, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("freed_iready", instr_req_ready, 1'b1);
    check("freed_addr", mem_req_addr, 32'h300);
    push_exp(1'b0, 32'h1111_0300);
    tick();
    instr_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) do_rsp($sformatf("drain%0d", k));

    // Lock: stalled fetch holds the port while data raises valid.
    instr_req_valid = 1'b1; instr_req_addr = 32'h400; mem_req_ready = 1'b0;
    #1;
    check("lock_mvld", mem_req_valid, 1'b1);
    check("lock_addr0", mem_req_addr, 32'h400);
    check("lock_iready0", instr_req_ready, 1'b0);
    tick();
    data_req_valid = 1'b1; data_req_wr = 1'b0; data_req_size = 2'd2; data_req_addr = 32'h5000;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("lock%0d_addr", k), mem_req_addr, 32'h400);
      check($sformatf("lock%0d_dready", k), data_req_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    check("lock_rel_iready", instr_req_ready, 1'b1);
    check("lock_rel_dready", data_req_ready, 1'b0);
    push_exp(1'b0, 32'hAAAA_0400);
    tick();
    instr_req_valid = 1'b0;
    #1;
    check("after_lock_dready", data_req_ready, 1'b1);
    check("after_lock_addr", mem_req_addr, 32'h5000);
    push_exp(1'b1, 32'hBBBB_5000);
    tick();
    data_req_valid = 1'b0;
    do_rsp("lock_rsp0");
    do_rsp("lock_rsp1");

    // Store: no FIFO entry, so a following response is an error.
    do_req("store", 1'b1, 1'b1, 2'd0, 32'h600, 32'h0000_00AB, 32'h0, 1'b1);
    check("store_rspv", {instr_rsp_valid, data_rsp_valid}, 2'b00);
    check("store_err0", rsp_err, 1'b0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    #1;
    check("orphan_rspv", {instr_rsp_valid, data_rsp_valid}, 2'b00);
    tick();
    mem_rsp_valid = 1'b0;
    check("orphan_err", rsp_err, 1'b1);
    tick();
    tick();
    check("err_sticky", rsp_err, 1'b1);

    // Reset mid-flight discards outstanding IDs.
    do_req("rf0", 1'b0, 1'b0, 2'd2, 32'h700, 32'h0, 32'h0, 1'b0);
    do_req("rf1", 1'b0, 1'b0, 2'd2, 32'h704, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b0; instr_req_valid = 1'b1; instr_req_addr = 32'h708;
    #1;
    check("mrst_mvld", mem_req_valid, 1'b0);
    check("mrst_iready", instr_req_ready, 1'b0);
    check("mrst_err", rsp_err, 1'b0);
    tick();
    reset_n = 1'b1; instr_req_valid = 1'b0;
    #1;
    check("post_rst_err", rsp_err, 1'b0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
    #1;
    check("late_rspv", {instr_rsp_valid, data_rsp_valid}, 2'b00);
    tick();
    mem_rsp_valid = 1'b0;
    check("late_err", rsp_err, 1'b1);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
